// File: rtl/rv_pkg.sv
// rv_pkg: funct3 access codes, LSU FSM state encoding and the access-size mask helper
package rv_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  function automatic logic [2:0] size_mask(input logic [2:0] f3);
    return (3'd1 << f3[1:0]) - 3'd1;
  endfunction
endpackage

// File: rtl/rv_lsu_align.sv
// rv_lsu_align: byte-enable generation, store lane shift and load extract/extend
module rv_lsu_align
  import rv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [2:0]  offset,
  input  logic [63:0] wdata,
  input  logic [63:0] rdata,
  output logic [7:0]  be,
  output logic [63:0] wdata_sh,
  output logic [63:0] rdata_ext
);
  logic [63:0] sh;
  // lanes start at the byte offset; load data is brought down to lane 0 then extended
  always_comb begin
    be = (funct3[1:0] == 2'd0 ? 8'h01 : funct3[1:0] == 2'd1 ? 8'h03 : funct3[1:0] == 2'd2 ? 8'h0F : 8'hFF) << offset;
    wdata_sh = wdata << {offset, 3'b000};
    sh = rdata >> {offset, 3'b000};
    case (funct3)
      F3_B:    rdata_ext = {{56{sh[7]}}, sh[7:0]};
      F3_H:    rdata_ext = {{48{sh[15]}}, sh[15:0]};
      F3_W:    rdata_ext = {{32{sh[31]}}, sh[31:0]};
      F3_BU:   rdata_ext = {56'd0, sh[7:0]};
      F3_HU:   rdata_ext = {48'd0, sh[15:0]};
      F3_WU:   rdata_ext = {32'd0, sh[31:0]};
      default: rdata_ext = sh;
    endcase
  end
endmodule

// File: rtl/rv_lsu.sv
// rv_lsu: single-outstanding load/store unit; RV_LSU_MISALIGN_TRAP_EN makes misaligned accesses illegal
module rv_lsu
  import rv_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [DATA_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  input  logic [4:0]        req_rd_i,
  output logic              resp_valid_o,
  output logic [DATA_W-1:0] resp_data_o,
  output logic [4:0]        resp_rd_o,
  output logic              resp_err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_be_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);
  state_t state, next;
  logic we_q, err_q, accept, bad_f3, illegal, unused_addr;
  logic [2:0] f3_q, mask;
  logic [ADDR_W-1:0] addr_q, addr_eff;
  logic [DATA_W-1:0] wdata_q, rdata_q, wsh, rext;
  logic [4:0] rd_q;
  logic [7:0] be;
  assign accept = req_valid_i & req_ready_o;
  assign mask = size_mask(req_funct3_i);
  assign bad_f3 = req_we_i ? req_funct3_i[2] : &req_funct3_i;
  assign unused_addr = ^req_addr_i[DATA_W-1:ADDR_W];
`ifdef RV_LSU_MISALIGN_TRAP_EN
  assign illegal = bad_f3 | (|(req_addr_i[2:0] & mask));
  assign addr_eff = req_addr_i[ADDR_W-1:0];
`else
  assign illegal = bad_f3;
  assign addr_eff = {req_addr_i[ADDR_W-1:3], req_addr_i[2:0] & ~mask};
`endif
  rv_lsu_align u_align (
    .funct3(f3_q),
    .offset(addr_q[2:0]),
    .wdata(wdata_q),
    .rdata(rdata_q),
    .be(be),
    .wdata_sh(wsh),
    .rdata_ext(rext)
  );
  // FSM state register
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else state <= next;
  // next-state and state-decoded outputs
  always_comb begin
    next = state;
    case (state)
      IDLE:    if (accept) next = illegal ? RESP : REQ;
      REQ:     if (mem_gnt_i) next = we_q ? RESP : WAIT;
      WAIT:    if (mem_rvalid_i) next = RESP;
      default: next = IDLE;
    endcase
    req_ready_o  = state == IDLE;
    mem_req_o    = state == REQ;
    mem_we_o     = mem_req_o & we_q;
    mem_addr_o   = mem_req_o ? {addr_q[ADDR_W-1:3], 3'b000} : '0;
    mem_be_o     = mem_req_o ? be : 8'h00;
    mem_wdata_o  = mem_we_o ? wsh : '0;
    resp_valid_o = state == RESP;
    resp_err_o   = resp_valid_o & err_q;
    resp_data_o  = resp_valid_o & ~we_q & ~err_q ? rext : '0;
    resp_rd_o    = rd_q;
  end
  // request capture at acceptance and read-data capture in WAIT
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      we_q <= 1'b0;
      err_q <= 1'b0;
      f3_q <= 3'd0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rd_q <= 5'd0;
    end else begin
      if (accept) begin
        we_q <= req_we_i;
        err_q <= illegal;
        f3_q <= req_funct3_i;
        addr_q <= addr_eff;
        wdata_q <= req_wdata_i;
        rd_q <= req_rd_i;
      end
      if (state == WAIT && mem_rvalid_i) rdata_q <= mem_rdata_i;
    end
endmodule

// File: tb/tb_rv_lsu.sv
// tb_rv_lsu: vector table with a response scoreboard and a memory responder, plus a mid-access reset sequence
module tb_rv_lsu;
  import rv_pkg::*;
  typedef struct {
    logic we; logic [2:0] f3; logic [63:0] addr, wdata, rdata; int gd, rdl;
    logic e_req; logic [11:0] e_addr; logic [7:0] e_be; logic [63:0] e_wdata; logic e_err; logic [63:0] e_data;
  } vec_t;
  typedef struct { logic [63:0] data; logic err; logic [4:0] rd; } exp_t;
  logic clk = 0, rstn = 0;
  logic req_valid_i = 0, req_we_i = 0, mem_gnt_i = 0, mem_rvalid_i = 0;
  logic [2:0] req_funct3_i = 0;
  logic [63:0] req_addr_i = 0, req_wdata_i = 0, mem_rdata_i = 0;
  logic [4:0] req_rd_i = 0;
  logic req_ready_o, resp_valid_o, resp_err_o, mem_req_o, mem_we_o;
  logic [63:0] resp_data_o, mem_wdata_o;
  logic [4:0] resp_rd_o;
  logic [11:0] mem_addr_o;
  logic [7:0] mem_be_o;
  exp_t sbq[$];
  vec_t vt[16];
  int checks = 0, failures = 0;
  rv_lsu dut (
    .clk(clk), .rstn(rstn),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_funct3_i(req_funct3_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_rd_i(req_rd_i),
    .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o), .resp_rd_o(resp_rd_o), .resp_err_o(resp_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [63:0] addr, wdata, rdata,
                              input int gd, rdl, input logic e_req, input logic [11:0] e_addr,
                              input logic [7:0] e_be, input logic [63:0] e_wdata, input logic e_err,
                              input logic [63:0] e_data);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.gd = gd; v.rdl = rdl;
    v.e_req = e_req; v.e_addr = e_addr; v.e_be = e_be; v.e_wdata = e_wdata; v.e_err = e_err; v.e_data = e_data;
    return v;
  endfunction
  task automatic run(input vec_t v);
    exp_t e;
    int lat, cyc, nreq, nwait;
    bit granted, done, saw;
    logic [4:0] rd;
    rd = 5'($urandom_range(0, 31));
    lat = !v.e_req ? 1 : v.we ? 2 + v.gd : 3 + v.gd + v.rdl;
    cyc = 0; nreq = 0; nwait = 0; granted = 0; done = 0; saw = 0;
    @(negedge clk);
    chk("ready_idle", 64'(req_ready_o), 64'd1);
    req_valid_i = 1; req_we_i = v.we; req_funct3_i = v.f3; req_addr_i = v.addr; req_wdata_i = v.wdata; req_rd_i = rd;
    e.data = v.e_data; e.err = v.e_err; e.rd = rd;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    req_valid_i = 0; req_we_i = ~v.we; req_funct3_i = 3'($urandom); req_addr_i = {$urandom, $urandom};
    req_wdata_i = {$urandom, $urandom}; req_rd_i = ~rd;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = {$urandom, $urandom};
      if (resp_valid_o) begin
        if (sbq.size() == 0) begin
          checks++; failures++;
          $display("FAIL resp_unexpected actual=resp required=none");
        end else begin
          e = sbq.pop_front();
          chk("resp_data", resp_data_o, e.data);
          chk("resp_err", 64'(resp_err_o), 64'(e.err));
          chk("resp_rd", 64'(resp_rd_o), 64'(e.rd));
        end
        chk("latency", 64'(cyc), 64'(lat));
        chk("req_in_resp", 64'(mem_req_o), 64'd0);
        done = 1;
      end else begin
        chk("ready_busy", 64'(req_ready_o), 64'd0);
        chk("err_idle", 64'(resp_err_o), 64'd0);
        if (mem_req_o) begin
          saw = 1;
          chk("mem_addr", 64'(mem_addr_o), 64'(v.e_addr));
          chk("mem_be", 64'(mem_be_o), 64'(v.e_be));
          chk("mem_we", 64'(mem_we_o), 64'(v.we));
          if (v.we) chk("mem_wdata", mem_wdata_o, v.e_wdata);
          if (nreq == v.gd) begin mem_gnt_i = 1; granted = 1; end
          nreq++;
        end else if (granted && !v.we) begin
          if (nwait == v.rdl) begin mem_rvalid_i = 1; mem_rdata_i = v.rdata; end
          nwait++;
        end
      end
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL resp_timeout actual=none required=resp");
    end
    chk("mem_access", 64'(saw), 64'(v.e_req));
  endtask
  initial begin
    vt[0]  = mk(1, F3_D,  64'h010, 64'h1122334455667788, 0, 0, 0, 1, 12'h010, 8'hFF, 64'h1122334455667788, 0, 0);
    vt[1]  = mk(0, F3_B,  64'h003, 0, 64'h0000000080000000, 0, 0, 1, 12'h000, 8'h08, 0, 0, 64'hFFFFFFFFFFFFFF80);
    vt[2]  = mk(0, F3_BU, 64'h003, 0, 64'h0000000080000000, 0, 0, 1, 12'h000, 8'h08, 0, 0, 64'h80);
    vt[3]  = mk(0, F3_H,  64'h002, 0, 64'h0000000080010000, 1, 0, 1, 12'h000, 8'h0C, 0, 0, 64'hFFFFFFFFFFFF8001);
    vt[4]  = mk(0, F3_HU, 64'h00A, 0, 64'h00000000F00D0000, 0, 1, 1, 12'h008, 8'h0C, 0, 0, 64'hF00D);
    vt[5]  = mk(0, F3_W,  64'h004, 0, 64'h89ABCDEF00000000, 0, 0, 1, 12'h000, 8'hF0, 0, 0, 64'hFFFFFFFF89ABCDEF);
    vt[6]  = mk(0, F3_WU, 64'h004, 0, 64'h89ABCDEF00000000, 0, 0, 1, 12'h000, 8'hF0, 0, 0, 64'h89ABCDEF);
    vt[7]  = mk(0, F3_D,  64'h018, 0, 64'hDEADBEEFCAFEF00D, 3, 2, 1, 12'h018, 8'hFF, 0, 0, 64'hDEADBEEFCAFEF00D);
    vt[8]  = mk(1, F3_B,  64'h005, 64'hAB, 0, 0, 0, 1, 12'h000, 8'h20, 64'h0000AB0000000000, 0, 0);
    vt[9]  = mk(1, F3_H,  64'h006, 64'h1234, 0, 2, 0, 1, 12'h000, 8'hC0, 64'h1234000000000000, 0, 0);
    vt[10] = mk(1, F3_W,  64'h00C, 64'hCAFEBABE, 0, 0, 0, 1, 12'h008, 8'hF0, 64'hCAFEBABE00000000, 0, 0);
    vt[11] = mk(1, 3'b101, 64'h020, 64'h55, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    vt[12] = mk(0, 3'b111, 64'h020, 0, 64'h1, 0, 0, 0, 0, 0, 0, 1, 0);
    vt[14] = mk(0, F3_D,  64'hFFFFFFFFFFFFF010, 0, 64'h0123456789ABCDEF, 0, 0, 1, 12'h010, 8'hFF, 0, 0, 64'h0123456789ABCDEF);
`ifdef RV_LSU_MISALIGN_TRAP_EN
    vt[13] = mk(0, F3_W,  64'h006, 0, 64'h1122334455667788, 0, 0, 0, 0, 0, 0, 1, 0);
    vt[15] = mk(1, F3_D,  64'h013, 64'hA5A5A5A5A5A5A5A5, 0, 0, 0, 0, 0, 0, 0, 1, 0);
`else
    vt[13] = mk(0, F3_W,  64'h006, 0, 64'h1122334455667788, 0, 1, 1, 12'h000, 8'hF0, 0, 0, 64'h11223344);
    vt[15] = mk(1, F3_D,  64'h013, 64'hA5A5A5A5A5A5A5A5, 0, 0, 0, 1, 12'h010, 8'hFF, 64'hA5A5A5A5A5A5A5A5, 0, 0);
`endif
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(req_ready_o), 64'd1);
    chk("rst_mem_req", 64'(mem_req_o), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid_o), 64'd0);
    chk("rst_resp_err", 64'(resp_err_o), 64'd0);
    chk("rst_resp_data", resp_data_o, 64'd0);
    chk("rst_mem_be", 64'(mem_be_o), 64'd0);
    rstn = 1;
    for (int i = 0; i < 16; i++) run(vt[i]);
    @(negedge clk);
    req_valid_i = 1; req_we_i = 0; req_funct3_i = F3_D; req_addr_i = 64'h020; req_rd_i = 5'd7;
    @(posedge clk);
    #1 req_valid_i = 0;
    @(negedge clk);
    chk("rs_mem_req", 64'(mem_req_o), 64'd1);
    mem_gnt_i = 1;
    @(negedge clk);
    mem_gnt_i = 0;
    chk("rs_wait_ready", 64'(req_ready_o), 64'd0);
    #2 rstn = 0;
    #1;
    chk("rs_async_ready", 64'(req_ready_o), 64'd1);
    chk("rs_async_valid", 64'(resp_valid_o), 64'd0);
    @(negedge clk);
    rstn = 1;
    for (int i = 0; i < 4; i++) begin
      mem_rvalid_i = 1; mem_rdata_i = 64'hBAD0BAD0BAD0BAD0;
      @(negedge clk);
      chk("rs_no_resp", 64'(resp_valid_o), 64'd0);
      chk("rs_idle", 64'(req_ready_o), 64'd1);
    end
    mem_rvalid_i = 0;
    run(vt[7]);
    run(vt[0]);
    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
